// File: rtl/neuron_accumulate_activate.sv
// Sums NUM_INPUTS unsigned weighted terms plus a signed bias per frame, then saturates and presents the result.
// Optional build macro NEURON_RELU_EN: negative results are forced to 0 and only positive clamping is reported.
module neuron_accumulate_activate #(
  parameter int        NUM_INPUTS = 4,
  parameter int        DATA_W     = 32,
  parameter int signed THRESHOLD  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [DATA_W-1:0] bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_fire,
  output logic              out_sat,
  output logic              frame_err
);

  localparam int ACC_W = DATA_W + $clog2(NUM_INPUTS) + 2;
  localparam int EXT_W = ACC_W - DATA_W;
  localparam int CNT_W = $clog2(NUM_INPUTS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_INPUTS);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(EXT_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(EXT_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};
  localparam logic signed [DATA_W-1:0] THRESH = DATA_W'(THRESHOLD);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUT
  } state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]         out_data_q, out_data_d;
  logic                      out_fire_q, out_fire_d;
  logic                      out_sat_q, out_sat_d;
  logic                      frame_err_q, frame_err_d;

  logic                      accept;
  logic signed [ACC_W-1:0]   term_ext;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [DATA_W-1:0]  res_data;
  logic                      res_sat;
  logic                      res_fire;

  assign in_ready  = (state_q != OUT) & ~rst;
  assign accept    = in_valid & in_ready;
  assign term_ext  = {{EXT_W{1'b0}}, in_data};
  assign bias_ext  = {{EXT_W{bias[DATA_W-1]}}, bias};

  assign out_valid = (state_q == OUT);
  assign out_data  = out_data_q;
  assign out_fire  = out_fire_q;
  assign out_sat   = out_sat_q;
  assign frame_err = frame_err_q;

  // Clamp the sum as it will stand after this cycle's accept, ready to be latched on entry to OUT.
  always_comb begin
    res_sat  = 1'b0;
    res_data = acc_d[DATA_W-1:0];
    if (acc_d > SAT_MAX) begin
      res_data = SAT_MAX[DATA_W-1:0];
      res_sat  = 1'b1;
    end else if (acc_d < SAT_MIN) begin
`ifdef NEURON_RELU_EN
      res_data = '0;
`else
      res_data = SAT_MIN[DATA_W-1:0];
      res_sat  = 1'b1;
`endif
    end
`ifdef NEURON_RELU_EN
    else if (acc_d[ACC_W-1]) begin
      res_data = '0;
    end
`endif
    res_fire = (res_data >= THRESH);
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_fire_d  = out_fire_q;
    out_sat_d   = out_sat_q;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          if (state_q == IDLE) begin
            acc_d = bias_ext + term_ext;
            cnt_d = CNT_W'(1);
          end else begin
            acc_d = acc_q + term_ext;
            cnt_d = cnt_q + CNT_W'(1);
          end
          state_d = (cnt_d == CNT_LAST) ? OUT : ACCUM;
          // Frame end is purely count-driven; in_last only flags disagreement.
          frame_err_d = in_last ^ (cnt_d == CNT_LAST);
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_d == OUT) && (state_q != OUT)) begin
      out_data_d = res_data;
      out_fire_d = res_fire;
      out_sat_d  = res_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_fire_q  <= 1'b0;
      out_sat_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_fire_q  <= out_fire_d;
      out_sat_q   <= out_sat_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_neuron_accumulate_activate.sv
// Randomized and directed bench for neuron_accumulate_activate (NUM_INPUTS=4, DATA_W=32, THRESHOLD=0).
// Expected results come from a plain-arithmetic frame model; honours NEURON_RELU_EN when defined.
module tb_neuron_accumulate_activate;

  localparam int N = 4;

  typedef struct {
    longint data;
    bit     fire;
    bit     sat;
  } result_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [31:0] bias = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_fire;
  logic        out_sat;
  logic        frame_err;

  int testCount = 0;
  int failCount = 0;

  result_t expQ[$];
  int      frameBeats = 0;
  longint  modelSum = 0;
  bit      errNext = 1'b0;
  bit      expectValid = 1'b0;
  int      readyMode = 2;
  int      outCount = 0;
  int      errPulses = 0;
  longint  lastData = 0;
  longint  lastFire = 0;
  longint  lastSat = 0;

  neuron_accumulate_activate #(.NUM_INPUTS(N), .DATA_W(32), .THRESHOLD(0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_fire(out_fire), .out_sat(out_sat), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame result from the arithmetic rules: clamp to 32-bit signed range, optional ReLU, fire at >= 0.
  function automatic result_t modelResult(input longint s);
    result_t r;
    longint maxV = 64'sd2147483647;
    longint minV = -64'sd2147483648;
    r.sat = 1'b0;
    r.data = s;
    if (s > maxV) begin
      r.data = maxV;
      r.sat = 1'b1;
    end else if (s < minV) begin
      r.data = minV;
      r.sat = 1'b1;
    end
`ifdef NEURON_RELU_EN
    if (r.data < 0) begin
      r.data = 0;
      r.sat = 1'b0;
    end
`endif
    r.fire = (r.data >= 0);
    return r;
  endfunction

  // Offer one beat, wait for acceptance, and update the frame model. Call at posedge+1.
  task automatic applyStimulus(input logic [31:0] d, input logic l, input logic [31:0] b);
    int waitCycles = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    bias = b;
    @(negedge clk);
    while (!in_ready && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("accept_timeout", longint'(in_ready), 1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    frameBeats++;
    if (frameBeats == 1) modelSum = longint'($signed(b)) + longint'(d);
    else modelSum = modelSum + longint'(d);
    errNext = (l != (frameBeats == N));
    if (frameBeats == N) begin
      expQ.push_back(modelResult(modelSum));
      expectValid = 1'b1;
      frameBeats = 0;
    end
  endtask

  task automatic sendFrame(input logic [31:0] b, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3, input logic [3:0] lastMask,
                           input int maxGap);
    logic [31:0] terms[4];
    terms[0] = d0; terms[1] = d1; terms[2] = d2; terms[3] = d3;
    for (int i = 0; i < N; i++) begin
      applyStimulus(terms[i], lastMask[i], b);
      if (maxGap > 0) repeat ($urandom_range(0, maxGap)) @(posedge clk);
      #0;
    end
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1;
    in_valid = 1'b0;
    expQ.delete();
    frameBeats = 0;
    errNext = 1'b0;
    expectValid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int waitCycles = 0;
    readyMode = 2;
    while (expQ.size() != 0 && waitCycles < 200) begin
      @(posedge clk);
      waitCycles++;
    end
    @(posedge clk);
    #1;
    checkOutput("drain_pending", longint'(expQ.size()), 0);
  endtask

  // Downstream readiness, changed away from the sampling edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (readyMode)
        0: out_ready = ($urandom_range(0, 3) != 0);
        1: out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares every cycle against the model's expectations.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        checkOutput("in_ready_rst", longint'(in_ready), 0);
        errNext = 1'b0;
        expectValid = 1'b0;
      end else begin
        if (frame_err) errPulses++;
        checkOutput("frame_err", longint'(frame_err), longint'(errNext));
        errNext = 1'b0;
        if (expectValid) begin
          checkOutput("latency", longint'(out_valid), 1);
          expectValid = 1'b0;
        end
        if (out_valid) begin
          checkOutput("in_ready_out", longint'(in_ready), 0);
          if (expQ.size() == 0) begin
            checkOutput("unexpected_out", longint'(out_valid), 0);
          end else begin
            checkOutput("out_data", longint'($signed(out_data)), expQ[0].data);
            checkOutput("out_fire", longint'(out_fire), longint'(expQ[0].fire));
            checkOutput("out_sat", longint'(out_sat), longint'(expQ[0].sat));
            if (out_ready) begin
              lastData = longint'($signed(out_data));
              lastFire = longint'(out_fire);
              lastSat = longint'(out_sat);
              void'(expQ.pop_front());
              outCount++;
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int countBefore;
    int pulsesBefore;
    logic [31:0] rb;
    logic [3:0] rm;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", longint'(out_valid), 0);
    checkOutput("rst_out_data", longint'(out_data), 0);
    checkOutput("rst_out_fire", longint'(out_fire), 0);
    checkOutput("rst_out_sat", longint'(out_sat), 0);
    checkOutput("rst_frame_err", longint'(frame_err), 0);
    checkOutput("rst_in_ready", longint'(in_ready), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed: basic sum");
    sendFrame(-32'sd50, 10, 20, 30, 40, 4'b1000, 0);
    drain();
    checkOutput("t1_data", lastData, 50);
    checkOutput("t1_fire", lastFire, 1);
    checkOutput("t1_sat", lastSat, 0);

    $display("[TB] directed: negative sum");
    sendFrame(-32'sd200, 10, 20, 30, 40, 4'b1000, 0);
    drain();
`ifdef NEURON_RELU_EN
    checkOutput("t2_data", lastData, 0);
    checkOutput("t2_fire", lastFire, 1);
`else
    checkOutput("t2_data", lastData, -100);
    checkOutput("t2_fire", lastFire, 0);
`endif

    $display("[TB] directed: positive saturation");
    sendFrame(32'h7FFF_FFF0, 32'h20, 32'h20, 32'h20, 32'h20, 4'b1000, 0);
    drain();
    checkOutput("t3_data", lastData, 64'sd2147483647);
    checkOutput("t3_sat", lastSat, 1);
    checkOutput("t3_fire", lastFire, 1);

    $display("[TB] directed: negative saturation");
    sendFrame(32'h8000_0000, 0, 0, 0, 0, 4'b1000, 0);
    drain();
    sendFrame(32'h8000_0000, 0, 0, 0, 0, 4'b1000, 0);
    readyMode = 1;
    repeat (2) @(posedge clk);
    #1;
    drain();

    $display("[TB] directed: back-pressure");
    countBefore = outCount;
    readyMode = 1;
    sendFrame(32'd100, 1, 1, 1, 1, 4'b1000, 0);
    fork
      sendFrame(32'd5, 1, 2, 3, 4, 4'b1000, 0);
      begin
        repeat (6) @(posedge clk);
        #1;
        readyMode = 2;
      end
    join
    drain();
    checkOutput("t4_outputs", longint'(outCount - countBefore), 2);
    checkOutput("t4_data", lastData, 15);

    $display("[TB] directed: early in_last");
    pulsesBefore = errPulses;
    sendFrame(32'd7, 3, 3, 3, 3, 4'b1010, 0);
    drain();
    checkOutput("t5_pulses", longint'(errPulses - pulsesBefore), 1);
    checkOutput("t5_data", lastData, 19);

    $display("[TB] directed: reset mid-frame");
    countBefore = outCount;
    applyStimulus(32'd1000, 1'b0, 32'd500);
    applyStimulus(32'd1000, 1'b0, 32'd500);
    doReset(2);
    sendFrame(32'd0, 1, 2, 3, 4, 4'b1000, 0);
    drain();
    checkOutput("t6_outputs", longint'(outCount - countBefore), 1);
    checkOutput("t6_data", lastData, 10);

    $display("[TB] randomized frames");
    readyMode = 0;
    for (int f = 0; f < 60; f++) begin
      rb = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($signed($urandom_range(0, 2000)) - 1000);
      rm = ($urandom_range(0, 3) != 0) ? 4'b1000 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0)
        sendFrame(rb, $urandom(), $urandom(), $urandom(), $urandom(), rm, 2);
      else
        sendFrame(rb, $urandom_range(0, 500), $urandom_range(0, 500),
                  $urandom_range(0, 500), $urandom_range(0, 500), rm, 2);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
